// File: rtl/fetch_port_arbiter_if.sv
// Fetch-side and memory-side handshake bundle for fetch_port_arbiter.
// slave = the arbiter, master = the surrounding fetch/memory environment.
interface fetch_port_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [NUM_CH-1:0]        ch_req_valid;
  logic [NUM_CH*ADDR_W-1:0] ch_req_addr;
  logic [NUM_CH-1:0]        ch_req_ready;
  logic [NUM_CH-1:0]        ch_resp_valid;
  logic [DATA_W-1:0]        ch_resp_data;
  logic                     mem_req_valid;
  logic [ADDR_W-1:0]        mem_req_addr;
  logic                     mem_req_ready;
  logic                     mem_resp_valid;
  logic [DATA_W-1:0]        mem_resp_data;

  modport slave (
    input  ch_req_valid, ch_req_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
    output ch_req_ready, ch_resp_valid, ch_resp_data, mem_req_valid, mem_req_addr
  );

  modport master (
    output ch_req_valid, ch_req_addr, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  ch_req_ready, ch_resp_valid, ch_resp_data, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/fetch_port_arbiter.sv
// N-channel fetch arbiter onto one in-order memory port, with a tag FIFO routing responses back.
// Define FETCH_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module fetch_port_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 64,
  parameter int OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  fetch_port_arbiter_if.slave           bus,
  output logic [$clog2(OUTSTANDING):0]  outstanding,
  output logic                          orphan_err
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam int OCC_W = PTR_W + 1;

  function automatic logic [CH_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
    lowest_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = CH_W'(i);
    end
  endfunction

  logic              any_vld_p0;
  logic              full_p0;
  logic              fire_p0;
  logic              pop_p0;
  logic [CH_W-1:0]   sel_p0;
  logic [ADDR_W-1:0] sel_addr_p0;
  logic [CH_W-1:0]   head_tag_p0;

  logic [CH_W-1:0]   tag_mem [OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  occ;

  logic [NUM_CH-1:0] resp_vld_p1;
  logic [DATA_W-1:0] resp_data_p1;
  logic              orphan_q;

  // ---- p0: combinational arbitration and request handshake ----
`ifdef FETCH_ARB_FIXED_PRIO_EN
  assign sel_p0 = lowest_set(bus.ch_req_valid);
`else
  logic [CH_W-1:0]   rr_ptr;
  logic [NUM_CH-1:0] at_or_above_rr;

  // Search from rr_ptr upward first, then wrap to the lowest valid channel.
  assign at_or_above_rr = bus.ch_req_valid & ~((NUM_CH'(1) << rr_ptr) - NUM_CH'(1));
  assign sel_p0 = (|at_or_above_rr) ? lowest_set(at_or_above_rr)
                                    : lowest_set(bus.ch_req_valid);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (fire_p0) begin
      rr_ptr <= (sel_p0 == CH_W'(NUM_CH - 1)) ? '0 : sel_p0 + 1'b1;
    end
  end
`endif

  assign any_vld_p0 = |bus.ch_req_valid;
  assign full_p0    = (occ == OCC_W'(OUTSTANDING));

  // rst gating keeps the request side quiet for the whole reset window.
  assign bus.mem_req_valid = rst & any_vld_p0 & ~full_p0;
  assign fire_p0           = bus.mem_req_valid & bus.mem_req_ready;

  always_comb begin
    sel_addr_p0 = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_p0 == CH_W'(i)) sel_addr_p0 = bus.ch_req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign bus.mem_req_addr = any_vld_p0 ? sel_addr_p0 : '0;

  always_comb begin
    bus.ch_req_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bus.ch_req_ready[i] = fire_p0 && (sel_p0 == CH_W'(i));
    end
  end

  // ---- p0: tag FIFO (push on fire, pop on a matched response) ----
  assign pop_p0      = bus.mem_resp_valid && (occ != '0);
  assign head_tag_p0 = tag_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (fire_p0) tag_mem[wr_ptr] <= sel_p0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (fire_p0) wr_ptr <= wr_ptr + 1'b1;
      if (pop_p0)  rd_ptr <= rd_ptr + 1'b1;
      case ({fire_p0, pop_p0})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // ---- p1: registered response routing ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_vld_p1  <= '0;
      resp_data_p1 <= '0;
      orphan_q     <= 1'b0;
    end else begin
      resp_vld_p1 <= pop_p0 ? (NUM_CH'(1) << head_tag_p0) : '0;
      if (pop_p0) resp_data_p1 <= bus.mem_resp_data;
      // A response with no tag to match can only come from a desynchronised memory side.
      if (bus.mem_resp_valid && (occ == '0)) orphan_q <= 1'b1;
    end
  end

  assign bus.ch_resp_valid = resp_vld_p1;
  assign bus.ch_resp_data  = resp_data_p1;
  assign outstanding       = occ;
  assign orphan_err        = orphan_q;

endmodule

// File: tb/tb_fetch_port_arbiter.sv
// Self-checking bench for fetch_port_arbiter: directed table, corner sequences, then
// randomized traffic against a queue-based reference model.
module tb_fetch_port_arbiter;
  localparam int NUM_CH      = 4;
  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 64;
  localparam int OUTSTANDING = 4;
  localparam int OCC_W       = $clog2(OUTSTANDING) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [OCC_W-1:0] outstanding;
  logic             orphan_err;

  logic [NUM_CH-1:0] vld   = '0;
  logic [ADDR_W-1:0] addr [NUM_CH];
  logic              mrdy  = 1'b0;
  logic              rvld  = 1'b0;
  logic [DATA_W-1:0] rdata = '0;

  fetch_port_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fetch_port_arbiter #(
    .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUTSTANDING(OUTSTANDING)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .outstanding(outstanding), .orphan_err(orphan_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    bus.ch_req_valid = vld;
    bus.ch_req_addr  = '0;
    for (int i = 0; i < NUM_CH; i++) bus.ch_req_addr[i*ADDR_W +: ADDR_W] = addr[i];
  end
  assign bus.mem_req_ready  = mrdy;
  assign bus.mem_resp_valid = rvld;
  assign bus.mem_resp_data  = rdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int                tagq[$];
  logic [ADDR_W-1:0] memq[$];
  int                rr       = 0;
  logic              m_orphan = 1'b0;
  logic [NUM_CH-1:0] m_resp   = '0;
  logic [DATA_W-1:0] m_data   = '0;
  int                g_last   = -1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int model_sel(logic [NUM_CH-1:0] v);
`ifdef FETCH_ARB_FIXED_PRIO_EN
    for (int k = 0; k < NUM_CH; k++) if (v[k]) return k;
`else
    for (int k = 0; k < NUM_CH; k++) if (v[(rr + k) % NUM_CH]) return (rr + k) % NUM_CH;
`endif
    return -1;
  endfunction

  function automatic void model_reset();
    tagq.delete();
    memq.delete();
    rr       = 0;
    m_orphan = 1'b0;
    m_resp   = '0;
    m_data   = '0;
  endfunction

  // Compare all DUT outputs against the model, then advance the model by one clock.
  function automatic void model_step();
    int s;
    bit mv, fire;
    s    = model_sel(vld);
    mv   = (s >= 0) && (tagq.size() < OUTSTANDING);
    fire = mv && mrdy;
    chk("mem_req_valid", bus.mem_req_valid, mv);
    chk("mem_req_addr", bus.mem_req_addr, (s >= 0) ? addr[s] : '0);
    chk("ch_req_ready", bus.ch_req_ready, fire ? (NUM_CH'(1) << s) : '0);
    chk("outstanding", outstanding, tagq.size());
    chk("orphan_err", orphan_err, m_orphan);
    chk("ch_resp_valid", bus.ch_resp_valid, m_resp);
    if (m_resp != '0) chk("ch_resp_data", bus.ch_resp_data, m_data);
    m_resp = '0;
    if (rvld) begin
      if (tagq.size() > 0) begin
        m_resp = NUM_CH'(1) << tagq.pop_front();
        m_data = rdata;
      end else begin
        m_orphan = 1'b1;
      end
      if (memq.size() > 0) void'(memq.pop_front());
    end
    g_last = fire ? s : -1;
    if (fire) begin
      tagq.push_back(s);
      memq.push_back(addr[s]);
      rr = (s + 1) % NUM_CH;
    end
  endfunction

  task automatic finish_cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle();
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic drain();
    vld = '0;
    for (int k = 0; k < 3 * OUTSTANDING && tagq.size() > 0; k++) begin
      rvld  = 1'b1;
      rdata = {32'hD0D0_0000, 32'(k)};
      cycle();
    end
    rvld = 1'b0;
    cycle();
    chk("drain_outstanding", outstanding, 0);
  endtask

  typedef struct {
    logic [NUM_CH-1:0] vld;
    logic              mrdy;
    logic              rvld;
    logic [DATA_W-1:0] rdata;
    logic [NUM_CH-1:0] e_rdy;
    int                e_outst;
    logic [NUM_CH-1:0] e_resp;
    logic [DATA_W-1:0] e_data;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #200000;
    $display("FAIL watchdog: test did not complete (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NUM_CH-1:0] pend;

    // Round-robin alternation between ch0 (0x100) and ch1 (0x200), memory latency 2.
    tbl[0] = '{4'b0011, 1'b1, 1'b0, 64'h0,   4'b0001, 0, 4'b0000, 64'h0};
    tbl[1] = '{4'b0011, 1'b1, 1'b0, 64'h0,   4'b0010, 1, 4'b0000, 64'h0};
    tbl[2] = '{4'b0011, 1'b1, 1'b1, 64'h100, 4'b0001, 2, 4'b0000, 64'h0};
    tbl[3] = '{4'b0011, 1'b1, 1'b1, 64'h200, 4'b0010, 2, 4'b0001, 64'h100};
    tbl[4] = '{4'b0011, 1'b1, 1'b1, 64'h100, 4'b0001, 2, 4'b0010, 64'h200};
    tbl[5] = '{4'b0000, 1'b1, 1'b1, 64'h200, 4'b0000, 2, 4'b0001, 64'h100};
    tbl[6] = '{4'b0000, 1'b1, 1'b1, 64'h100, 4'b0000, 1, 4'b0010, 64'h200};
    tbl[7] = '{4'b0000, 1'b1, 1'b0, 64'h0,   4'b0000, 0, 4'b0001, 64'h100};
    tbl[8] = '{4'b0000, 1'b1, 1'b0, 64'h0,   4'b0000, 0, 4'b0000, 64'h0};

    for (int i = 0; i < NUM_CH; i++) addr[i] = ADDR_W'(32'h100 * (i + 1));

    // Asynchronous reset with requests pending: outputs forced without any clock edge.
    vld = '1;
    #1 rst = 1'b0;
    #1;
    chk("rst_mem_req_valid", bus.mem_req_valid, 0);
    chk("rst_ch_req_ready", bus.ch_req_ready, 0);
    chk("rst_ch_resp_valid", bus.ch_resp_valid, 0);
    chk("rst_ch_resp_data", bus.ch_resp_data, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_orphan_err", orphan_err, 0);
    vld = '0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

`ifndef FETCH_ARB_FIXED_PRIO_EN
    for (int r = 0; r < 9; r++) begin
      vld = tbl[r].vld; mrdy = tbl[r].mrdy; rvld = tbl[r].rvld; rdata = tbl[r].rdata;
      @(negedge clk);
      chk($sformatf("A%0d_ready", r), bus.ch_req_ready, tbl[r].e_rdy);
      chk($sformatf("A%0d_outstanding", r), outstanding, tbl[r].e_outst);
      chk($sformatf("A%0d_resp_valid", r), bus.ch_resp_valid, tbl[r].e_resp);
      if (tbl[r].e_resp != '0) chk($sformatf("A%0d_resp_data", r), bus.ch_resp_data, tbl[r].e_data);
      finish_cycle();
    end

    // ch2 alone three times leaves rr_ptr at 3, so ch3 beats ch0.
    vld = 4'b0100; addr[2] = 32'h300; rvld = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("B_ch2_ready", bus.ch_req_ready, 4'b0100);
      finish_cycle();
    end
    drain();
    vld = 4'b1001; addr[0] = 32'h400; addr[3] = 32'h500;
    @(negedge clk);
    chk("B_ch3_first", bus.ch_req_ready, 4'b1000);
    finish_cycle();
    @(negedge clk);
    chk("B_ch0_second", bus.ch_req_ready, 4'b0001);
    finish_cycle();
    drain();
`else
    // Fixed priority: ch0 wins every cycle while it stays valid.
    vld = '1; mrdy = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rvld = (k > 0); rdata = DATA_W'(k);
      @(negedge clk);
      chk("FP_ch0_ready", bus.ch_req_ready, 4'b0001);
      finish_cycle();
    end
    vld = 4'b1110; rvld = 1'b1;
    @(negedge clk);
    chk("FP_ch1_ready", bus.ch_req_ready, 4'b0010);
    finish_cycle();
    drain();
`endif

    // Fill the tag FIFO with memory withholding responses.
    vld = 4'b0010; addr[1] = 32'h600; mrdy = 1'b1; rvld = 1'b0;
    repeat (4) cycle();
    rvld = 1'b1; rdata = 64'h600;
    @(negedge clk);
    chk("C_full_outstanding", outstanding, 4);
    chk("C_full_mem_req_valid", bus.mem_req_valid, 0);
    chk("C_full_ready", bus.ch_req_ready, 0);
    finish_cycle();
    rvld = 1'b0;
    @(negedge clk);
    chk("C_after_pop_outstanding", outstanding, 3);
    chk("C_after_pop_mem_req_valid", bus.mem_req_valid, 1);
    chk("C_after_pop_ready", bus.ch_req_ready, 4'b0010);
    finish_cycle();
    drain();

    // Response with an empty FIFO.
    vld = '0; rvld = 1'b1; rdata = 64'hBAD;
    @(negedge clk);
    chk("D_orphan_before", orphan_err, 0);
    finish_cycle();
    rvld = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("D_orphan_sticky", orphan_err, 1);
      chk("D_no_resp", bus.ch_resp_valid, 0);
      finish_cycle();
    end

    // Reset mid-operation with three tags outstanding.
    vld = 4'b0010; addr[1] = 32'h700;
    repeat (3) cycle();
    vld = '1;
    #2 rst = 1'b0;
    #1;
    chk("E_rst_mem_req_valid", bus.mem_req_valid, 0);
    chk("E_rst_ready", bus.ch_req_ready, 0);
    chk("E_rst_outstanding", outstanding, 0);
    chk("E_rst_orphan", orphan_err, 0);
    chk("E_rst_resp_valid", bus.ch_resp_valid, 0);
    chk("E_rst_resp_data", bus.ch_resp_data, 0);
    vld = '0;
    model_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    vld = 4'b0010; addr[1] = 32'h1000;
    @(negedge clk);
    chk("E_ch1_ready", bus.ch_req_ready, 4'b0010);
    chk("E_ch1_addr", bus.mem_req_addr, 32'h1000);
    finish_cycle();
    vld = '0; rvld = 1'b1; rdata = 64'hC0DE_0000_0000_1000;
    cycle();
    rvld = 1'b0;
    @(negedge clk);
    chk("E_resp_ch1_only", bus.ch_resp_valid, 4'b0010);
    chk("E_resp_data", bus.ch_resp_data, 64'hC0DE_0000_0000_1000);
    finish_cycle();

    // Randomized traffic; a channel holds its request until granted.
    pend = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          addr[i] = $urandom;
        end
      end
      vld   = pend;
      mrdy  = ($urandom_range(0, 3) != 0);
      rvld  = (memq.size() > 0) && ($urandom_range(0, 2) != 0);
      rdata = rvld ? {memq[0], ~memq[0]} : {$urandom, $urandom};
      @(negedge clk);
      model_step();
      if (g_last >= 0) pend[g_last] = 1'b0;
      @(posedge clk);
      #1;
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_port_arbiter.md
# fetch_port_arbiter

- Parametrised N-channel instruction-fetch arbiter between the processor's fetch request ports and a single in-order instruction memory port.
- Round-robin arbitrates up to NUM_CH fetch requests onto the memory port and records the granted channel ID in a tag FIFO.
- Routes each in-order memory response back to the channel that issued it.
- Generalises the current fixed two-port fetch pair (Inst1/Inst2) to any channel count, and adds outstanding-request tracking and an error flag for unmatched responses.

## Interface
Parameters:
- NUM_CH, 2, number of fetch channels (2..8)
- ADDR_W, 32, fetch address width
- DATA_W, 64, fetch data width per response
- OUTSTANDING, 4, tag FIFO depth; power of two, 2..16

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous active-low reset; clk is the only clock
- ch_req_valid  in  NUM_CH  per-channel fetch request valid
- ch_req_addr  in  NUM_CH*ADDR_W  per-channel address; channel i at [i*ADDR_W +: ADDR_W]
- ch_req_ready  out  NUM_CH  per-channel accept
- ch_resp_valid  out  NUM_CH  one-hot response strobe
- ch_resp_data  out  DATA_W  response data, shared by all channels
- mem_req_valid  out  1  memory request valid
- mem_req_addr  out  ADDR_W  memory request address
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  memory response, in request order, no backpressure
- mem_resp_data  in  DATA_W  memory response data
- outstanding  out  $clog2(OUTSTANDING)+1  tag FIFO occupancy
- orphan_err  out  1  sticky: response arrived with tag FIFO empty

## Operation
- Arbitration is combinational over ch_req_valid, starting from rr_ptr and wrapping. sel is the first valid channel at index >= rr_ptr, else the lowest valid index below rr_ptr.
- mem_req_valid = (|ch_req_valid) & !full.
- mem_req_addr = address of sel; 0 when no channel is valid.
- ch_req_ready[i] = (i==sel) & mem_req_valid & mem_req_ready. At most one bit is set.
- Handshake fire = mem_req_valid & mem_req_ready. On fire:
  - push sel into the tag FIFO;
  - rr_ptr <= sel+1, wrapping NUM_CH-1 -> 0.
- Without fire, rr_ptr holds.
- mem_req_valid never depends on mem_req_ready.
- A channel must hold valid and addr until it sees ready. The arbiter does not check this.
- On mem_resp_valid with the FIFO non-empty:
  - pop the head tag t;
  - next cycle: ch_resp_valid = 1<<t and ch_resp_data = mem_resp_data.
- On mem_resp_valid with the FIFO empty:
  - no pop, ch_resp_valid stays 0;
  - orphan_err is set and held until reset.
- Full means occupancy == OUTSTANDING. While full, all requests stall.
- A pop in the same cycle does not re-enable a push. This avoids a combinational path from mem_resp_valid to mem_req_valid.
- Simultaneous push and pop when not full: occupancy unchanged, FIFO order preserved.
- FIFO pointers wrap modulo OUTSTANDING. Occupancy uses a separate counter, one bit wider.

## Timing
- Request path is combinational: accept happens in the cycle of the handshake, zero added latency.
- Response path: 1 cycle. mem_resp_valid at cycle n gives ch_resp_valid at n+1.
- A response can return in the cycle right after fire; its tag is already visible.
- Back-to-back: one request per cycle and one response per cycle are sustained.
- Reset (rst low), asynchronous; takes effect immediately, with no clock edge needed:
  - rr_ptr = 0, FIFO emptied, outstanding = 0;
  - ch_resp_valid = 0, ch_resp_data = 0, orphan_err = 0;
  - mem_req_valid and ch_req_ready forced to 0 while rst is low.
- Reset mid-operation drops in-flight tags. Responses to those requests that arrive after reset set orphan_err. The memory side must be reset together with this block.

## Configuration
- Macro FETCH_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest-index valid channel wins. rr_ptr is removed and all other behaviour is unchanged.
- Undefined (default): round-robin as described in Operation.

## Test plan
- NUM_CH=2, both channels valid every cycle, mem_req_ready=1:
  - grants alternate 0,1,0,1;
  - with memory returning at fixed 2-cycle latency, ch_resp_valid follows as 01,10,01,10 with data matching the addresses.
- NUM_CH=4, only ch2 valid, 3 requests; then ch0 and ch3 valid from rr_ptr=3:
  - ch3 is granted first, then ch0.
- OUTSTANDING=4 with memory withholding responses:
  - after 4 fires, outstanding=4, mem_req_valid=0, all ch_req_ready=0;
  - one mem_resp_valid brings outstanding to 3, and the next cycle accepts a request.
- mem_resp_valid asserted at idle with the FIFO empty:
  - orphan_err=1 next cycle and stays 1; ch_resp_valid stays 0.
- Reset mid-operation:
  - with 3 tags outstanding, pull rst low mid-cycle;
  - outputs go to reset values immediately and outstanding=0;
  - after release, ch1 request at 0x1000 is granted and its response reaches ch1 only.
- With FETCH_ARB_FIXED_PRIO_EN defined and all channels valid continuously:
  - ch0 is granted every cycle, and ch1..ch3 only once ch0 drops valid.
